// File: rtl/tiger_pkg.sv
// Shared constants, word types and FSM encoding for the Tiger key schedule.
package tiger_pkg;

    localparam int WORD_W  = 64;
    localparam int N_WORDS = 8;
    localparam int KEY_W   = WORD_W * N_WORDS;

    typedef logic [WORD_W-1:0] word_t;

    // Half A whitening constant and half B final-word constant.
    localparam word_t C1 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam word_t C2 = 64'h0123_4567_89AB_CDEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HA   = 2'd1,
        ST_HB   = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/tiger_ks_half.sv
// One half of the Tiger key schedule (HALF=0 -> half A, HALF=1 -> half B).
// Purely combinational; word x0 sits in the top 64 bits of the bus.
module tiger_ks_half
    import tiger_pkg::*;
#(
    parameter int HALF = 0
) (
    input  logic [KEY_W-1:0] x_in,
    output logic [KEY_W-1:0] y_out
);

    word_t x [N_WORDS];
    word_t y [N_WORDS];

    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_pack
        assign x[gi] = x_in[KEY_W-1-WORD_W*gi -: WORD_W];
        assign y_out[KEY_W-1-WORD_W*gi -: WORD_W] = y[gi];
    end

    if (HALF == 0) begin : g_half_a
        // Forward chain: each word mixes with its predecessor result.
        assign y[0] = x[0] - (x[7] ^ C1);
        assign y[1] = x[1] ^ y[0];
        assign y[2] = x[2] + y[1];
        assign y[3] = x[3] - (y[2] ^ ((~y[1]) << 19));
        assign y[4] = x[4] ^ y[3];
        assign y[5] = x[5] + y[4];
        assign y[6] = x[6] - (y[5] ^ ((~y[4]) >> 23));
        assign y[7] = x[7] ^ y[6];
    end else begin : g_half_b
        // Second chain, seeded by the wrap-around word x7.
        assign y[0] = x[0] + x[7];
        assign y[1] = x[1] - (y[0] ^ ((~x[7]) << 19));
        assign y[2] = x[2] ^ y[1];
        assign y[3] = x[3] + y[2];
        assign y[4] = x[4] - (y[3] ^ ((~y[2]) >> 23));
        assign y[5] = x[5] ^ y[4];
        assign y[6] = x[6] + y[5];
        assign y[7] = x[7] - (y[6] ^ C2);
    end

endmodule

// File: rtl/tiger_key_sch_iter.sv
// Iterative Tiger key schedule: one half per cycle, PASSES-1 chained
// schedules per accepted message block, valid/ready on both sides.
module tiger_key_sch_iter
    import tiger_pkg::*;
#(
    parameter int PASSES = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [KEY_W-1:0] i_key,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [KEY_W-1:0] o_key,
    output logic [2:0]       o_idx,
    output logic             o_last
);

    localparam logic [2:0] LAST_IDX = 3'(PASSES - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [2:0]       idx_reg;
    logic [KEY_W-1:0] r_key;
    logic [KEY_W-1:0] r_xa;
    logic [KEY_W-1:0] ha_out;
    logic [KEY_W-1:0] hb_out;
    logic             last_sched;

    tiger_ks_half #(.HALF(0)) u_half_a (.x_in(r_key), .y_out(ha_out));
    tiger_ks_half #(.HALF(1)) u_half_b (.x_in(r_xa),  .y_out(hb_out));

    assign last_sched = (idx_reg == LAST_IDX);

    // Next-state: accept, two half steps, then hold output until consumed.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (i_vld) state_next = ST_HA;
            ST_HA:   state_next = ST_HB;
            ST_HB:   state_next = ST_OUT;
            ST_OUT:  if (i_rdy) state_next = last_sched ? ST_IDLE : ST_HA;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: load key, latch half A, fold half B back into r_key, count schedules.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key   <= '0;
            r_xa    <= '0;
            idx_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: if (i_vld) begin
                    r_key   <= i_key;
                    idx_reg <= 3'd1;
                end
                ST_HA:   r_xa  <= ha_out;
                ST_HB:   r_key <= hb_out;
                ST_OUT:  if (i_rdy && !last_sched) idx_reg <= idx_reg + 3'd1;
                default: ;
            endcase
        end
    end

    assign o_rdy  = (state_reg == ST_IDLE);
    assign o_vld  = (state_reg == ST_OUT);
    assign o_last = o_vld && last_sched;
    assign o_key  = r_key;
    assign o_idx  = idx_reg;

endmodule

// File: tb/tb_tiger_key_sch_iter.sv
// Directed + random bench for tiger_key_sch_iter with a scoreboard of
// expected schedules and a cycle model of the handshake timing.
module tb_tiger_key_sch_iter;

    localparam int P  = 3;
    localparam int P8 = 8;

    typedef struct packed {
        logic [511:0] key;
        logic [2:0]   idx;
        logic         last;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         i_vld, i_rdy, o_rdy, o_vld, o_last;
    logic [511:0] i_key, o_key;
    logic [2:0]   o_idx;
    logic         vld8, rdy8, o_rdy8, o_vld8, o_last8;
    logic [511:0] key8, o_key8;
    logic [2:0]   o_idx8;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   ph     = 0;   // 0 idle, 1 half A, 2 half B, 3 output
    int   n_acc  = 0;
    exp_t sb[$];

    tiger_key_sch_iter #(.PASSES(P)) dut (
        .i_clk(clk), .i_rst(rst), .i_vld(i_vld), .o_rdy(o_rdy), .i_key(i_key),
        .o_vld(o_vld), .i_rdy(i_rdy), .o_key(o_key), .o_idx(o_idx), .o_last(o_last)
    );

    tiger_key_sch_iter #(.PASSES(P8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_vld(vld8), .o_rdy(o_rdy8), .i_key(key8),
        .o_vld(o_vld8), .i_rdy(rdy8), .o_key(o_key8), .o_idx(o_idx8), .o_last(o_last8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] sched(input logic [511:0] k);
        logic [63:0]  x [8];
        logic [63:0]  a [8];
        logic [63:0]  b [8];
        logic [511:0] r;
        for (int i = 0; i < 8; i++) x[i] = k[511-64*i -: 64];
        a[0] = x[0] - (x[7] ^ 64'hA5A5A5A5A5A5A5A5);
        a[1] = x[1] ^ a[0];
        a[2] = x[2] + a[1];
        a[3] = x[3] - (a[2] ^ ((~a[1]) << 19));
        a[4] = x[4] ^ a[3];
        a[5] = x[5] + a[4];
        a[6] = x[6] - (a[5] ^ ((~a[4]) >> 23));
        a[7] = x[7] ^ a[6];
        b[0] = a[0] + a[7];
        b[1] = a[1] - (b[0] ^ ((~a[7]) << 19));
        b[2] = a[2] ^ b[1];
        b[3] = a[3] + b[2];
        b[4] = a[4] - (b[3] ^ ((~b[2]) >> 23));
        b[5] = a[5] ^ b[4];
        b[6] = a[6] + b[5];
        b[7] = a[7] - (b[6] ^ 64'h0123456789ABCDEF);
        r = '0;
        for (int i = 0; i < 8; i++) r[511-64*i -: 64] = b[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_key();
        logic [511:0] k;
        for (int i = 0; i < 16; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_block(input logic [511:0] k);
        logic [511:0] cur;
        cur = k;
        for (int j = 1; j < P; j++) begin
            cur = sched(cur);
            sb.push_back('{key: cur, idx: 3'(j), last: (j == P - 1)});
        end
    endtask

    // One clock of DUT1: check outputs mid-cycle, advance model on the inputs
    // that will be sampled at the coming edge, then return just after it.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        chk_bit("o_rdy", o_rdy, ph == 0);
        chk_bit("o_vld", o_vld, ph == 3);
        if (ph == 3 && sb.size() > 0) begin
            e = sb[0];
            chk_vec("o_key", o_key, e.key);
            chk_vec("o_idx", 512'(o_idx), 512'(e.idx));
            chk_bit("o_last", o_last, e.last);
        end
        case (ph)
            0: if (i_vld) begin push_block(i_key); n_acc++; ph = 1; end
            1: ph = 2;
            2: ph = 3;
            default: if (i_rdy) begin
                e  = sb.pop_front();
                ph = e.last ? 0 : 1;
            end
        endcase
        $display("cyc t=%0t vld=%b rdy=%b idx=%0d last=%b ph=%0d", $time, o_vld, o_rdy, o_idx, o_last, ph);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((ph != 0 || sb.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk_bit("drain_in_budget", n < budget, 1'b1);
    endtask

    initial begin
        int w;
        int cyc;
        logic [511:0] exp8;

        rst = 1'b0; i_vld = 1'b0; i_rdy = 1'b1; i_key = '0;
        vld8 = 1'b0; rdy8 = 1'b1; key8 = '0;
        #1 rst = 1'b1;
        #1;
        // Reset state
        chk_bit("rst_o_rdy", o_rdy, 1'b1);
        chk_bit("rst_o_vld", o_vld, 1'b0);
        chk_bit("rst_o_last", o_last, 1'b0);
        chk_vec("rst_o_idx", 512'(o_idx), 512'd0);
        chk_vec("rst_o_key", o_key, 512'd0);
        chk_bit("rst_o_rdy8", o_rdy8, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single zero block; acceptance on the first edge after reset release
        i_vld = 1'b1; i_key = '0; i_rdy = 1'b1;
        tick();
        i_vld = 1'b0;
        drain(30);

        // Back-pressure: hold i_rdy low 10 cycles while output is presented
        i_key = rand_key(); i_vld = 1'b1; i_rdy = 1'b0;
        tick();
        i_vld = 1'b0;
        repeat (12) tick();
        i_rdy = 1'b1;
        drain(30);

        // i_vld held high across two blocks, i_key scrambled every cycle
        i_vld = 1'b1;
        w = 0;
        while (n_acc < 4 && w < 40) begin
            i_key = rand_key();
            tick();
            w++;
        end
        chk_bit("two_blocks_accepted", n_acc >= 4, 1'b1);
        i_vld = 1'b0;
        drain(30);

        // Reset during half B of schedule 2
        i_key = rand_key(); i_vld = 1'b1;
        tick();
        i_vld = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk_bit("midrst_o_vld", o_vld, 1'b0);
        chk_bit("midrst_o_rdy", o_rdy, 1'b1);
        chk_vec("midrst_o_key", o_key, 512'd0);
        sb.delete();
        ph = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) tick();
        i_key = rand_key(); i_vld = 1'b1;
        tick();
        i_vld = 1'b0;
        drain(30);

        // PASSES=8 instance: seven chained schedules, fixed 3-edge spacing
        key8 = {8{64'h0123456789ABCDEF}};
        vld8 = 1'b1;
        @(posedge clk); #1;
        vld8 = 1'b0;
        exp8 = key8;
        for (int j = 1; j < P8; j++) begin
            exp8 = sched(exp8);
            w = 0;
            @(negedge clk);
            while (!o_vld8 && w < 10) begin
                @(negedge clk);
                w++;
            end
            chk_vec("p8_latency", 512'(w), 512'd2);
            chk_bit("p8_o_vld", o_vld8, 1'b1);
            chk_vec("p8_o_key", o_key8, exp8);
            chk_vec("p8_o_idx", 512'(o_idx8), 512'(j));
            chk_bit("p8_o_last", o_last8, j == P8 - 1);
            $display("p8 idx=%0d last=%b", o_idx8, o_last8);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk_bit("p8_idle_after", o_rdy8, 1'b1);
        @(posedge clk); #1;

        // Random traffic
        n_acc = 0;
        cyc = 0;
        while (n_acc < 300 && cyc < 20000) begin
            i_vld = 1'($urandom_range(0, 1));
            i_rdy = ($urandom_range(0, 3) != 0);
            i_key = rand_key();
            tick();
            cyc++;
        end
        chk_bit("rand_all_accepted", n_acc >= 300, 1'b1);
        i_vld = 1'b0;
        i_rdy = 1'b1;
        drain(60);
        chk_vec("sb_empty", 512'(sb.size()), 512'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
